match_scheduler: RTL and testbench



---
 rtl/match_scheduler_if.sv | 44 ++++
 rtl/match_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_match_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_scheduler_if.sv
// Bundle of requester, input-RAM, matcher and response signals
// for match_scheduler (slave = scheduler side, master = environment).
interface match_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    gnt;
    logic                  q_valid;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  q_last;
    logic                  q_ready;
    logic                  iram_we;
    logic [ADDR_WIDTH-1:0] iram_addr;
    logic [DATA_WIDTH-1:0] iram_din;
    logic                  m_rst_n;
    logic                  m_cs;
    logic                  m_done;
    logic                  m_found;
    logic [ADDR_WIDTH-1:0] m_addr_v;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_found;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_timeout;
    logic                  rsp_trunc;

    modport slave (
        input  req, q_valid, q_data, q_last,
        input  m_done, m_found, m_addr_v, rsp_ready,
        output gnt, q_ready, iram_we, iram_addr, iram_din,
        output m_rst_n, m_cs,
        output rsp_valid, rsp_found, rsp_addr, rsp_timeout, rsp_trunc
    );

    modport master (
        output req, q_valid, q_data, q_last,
        output m_done, m_found, m_addr_v, rsp_ready,
        input  gnt, q_ready, iram_we, iram_addr, iram_din,
        input  m_rst_n, m_cs,
        input  rsp_valid, rsp_found, rsp_addr, rsp_timeout, rsp_trunc
    );
endinterface

// File: rtl/match_scheduler.sv
// Round-robin scheduler sharing one vocab matcher and its input RAM.
// Optional job statistics counters: define MATCH_SCHED_STATS_EN.
module match_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic clk,
    input  logic rst,
    match_scheduler_if.slave bus
`ifdef MATCH_SCHED_STATS_EN
    ,
    output logic [15:0] stat_jobs,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_TERM,
        S_MRST,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  trunc_q, trunc_d;
    logic                  drop_q, drop_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  found_q, found_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  tmo_q, tmo_d;

    logic                  arb_hit;
    logic [IW-1:0]         arb_idx;
    logic [IW-1:0]         cand;
    logic                  q_ready;
    logic                  iram_we;
    logic [DATA_WIDTH-1:0] iram_din;
    logic                  m_rst_n;
    logic                  m_cs;
    logic                  rsp_valid;

    function automatic logic [IW-1:0] wrap_add(
        input logic [IW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_q, i);
            if (!arb_hit && bus.req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Job sequencing: next state, datapath updates and strobes.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gidx_d    = gidx_q;
        gnt_d     = gnt_q;
        wr_ptr_d  = wr_ptr_q;
        trunc_d   = trunc_q;
        drop_d    = drop_q;
        timer_d   = timer_q;
        found_d   = found_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        q_ready   = 1'b0;
        iram_we   = 1'b0;
        iram_din  = '0;
        m_rst_n   = 1'b0;
        m_cs      = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_hit) begin
                    gidx_d   = arb_idx;
                    gnt_d    = NUM_REQ'(1) << arb_idx;
                    wr_ptr_d = '0;
                    trunc_d  = 1'b0;
                    drop_d   = 1'b0;
                    found_d  = 1'b0;
                    addr_d   = '0;
                    tmo_d    = 1'b0;
                    state_d  = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                q_ready = 1'b1;
                if (bus.q_valid) begin
                    if (!drop_q) begin
                        if (bus.q_data == '0) begin
                            drop_d = 1'b1;
                        end else if (wr_ptr_q != PTR_MAX) begin
                            iram_we  = 1'b1;
                            iram_din = bus.q_data;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end else begin
                            trunc_d = 1'b1;
                        end
                    end
                    if (bus.q_last) state_d = S_TERM;
                end
            end
            S_TERM: begin
                iram_we = 1'b1;
                state_d = S_MRST;
            end
            S_MRST: begin
                state_d = S_START;
            end
            S_START: begin
                m_rst_n = 1'b1;
                m_cs    = 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                m_rst_n = 1'b1;
                if (bus.m_done) begin
                    found_d = bus.m_found;
                    addr_d  = bus.m_addr_v;
                    state_d = S_RESP;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    found_d = 1'b0;
                    addr_d  = '0;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                m_rst_n   = 1'b1;
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    gnt_d   = '0;
                    rr_d    = wrap_add(gidx_q, 1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            wr_ptr_q <= '0;
            trunc_q  <= 1'b0;
            drop_q   <= 1'b0;
            timer_q  <= '0;
            found_q  <= 1'b0;
            addr_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            wr_ptr_q <= wr_ptr_d;
            trunc_q  <= trunc_d;
            drop_q   <= drop_d;
            timer_q  <= timer_d;
            found_q  <= found_d;
            addr_q   <= addr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.q_ready     = q_ready;
    assign bus.iram_we     = iram_we;
    assign bus.iram_addr   = wr_ptr_q;
    assign bus.iram_din    = iram_din;
    assign bus.m_rst_n     = m_rst_n;
    assign bus.m_cs        = m_cs;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_found   = found_q;
    assign bus.rsp_addr    = addr_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.rsp_trunc   = trunc_q;

`ifdef MATCH_SCHED_STATS_EN
    logic [15:0] jobs_q, jobs_d;
    logic [15:0] hits_q, hits_d;
    logic [15:0] tmos_q, tmos_d;
    logic        rsp_hs;

    assign rsp_hs = (state_q == S_RESP) && bus.rsp_ready;

    // Saturating job counters, bumped on the response handshake.
    always_comb begin
        jobs_d = jobs_q;
        hits_d = hits_q;
        tmos_d = tmos_q;
        if (rsp_hs) begin
            if (jobs_q != 16'hFFFF) jobs_d = jobs_q + 1'b1;
            if (found_q && hits_q != 16'hFFFF) hits_d = hits_q + 1'b1;
            if (tmo_q && tmos_q != 16'hFFFF) tmos_d = tmos_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_q <= '0;
            hits_q <= '0;
            tmos_q <= '0;
        end else begin
            jobs_q <= jobs_d;
            hits_q <= hits_d;
            tmos_q <= tmos_d;
        end
    end

    assign stat_jobs     = jobs_q;
    assign stat_hits     = hits_q;
    assign stat_timeouts = tmos_q;
`endif

endmodule

// File: tb/tb_match_scheduler.sv
// Randomized self-checking bench for match_scheduler.
// Expected values come from a queue-based reference model of the job rules.
`timescale 1ns/1ps
module tb_match_scheduler;

    localparam int NREQ  = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int TMO   = 64;
    localparam int BOUND = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    match_scheduler_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MATCH_SCHED_STATS_EN
    logic [15:0] stat_jobs, stat_hits, stat_timeouts;
`endif

    match_scheduler #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MATCH_SCHED_STATS_EN
        ,
        .stat_jobs(stat_jobs),
        .stat_hits(stat_hits),
        .stat_timeouts(stat_timeouts)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rr_model = 0;

    logic [DW-1:0]    qbytes[$];
    logic [AW+DW-1:0] exp_w[$];
    logic [AW+DW-1:0] obs_w[$];
    bit               exp_trunc;

    int            obs_first_rdy, obs_cs_cnt, obs_cs_to_rsp, obs_accepted, obs_rsp_cycles;
    logic [NREQ-1:0] obs_gnt;
    bit            obs_gnt_ok, obs_mrst_ok, obs_stable, obs_bound;
    logic          obs_found, obs_tmo, obs_trunc;
    logic [AW-1:0] obs_addr;

    // Reference model: RAM image expected from the query bytes.
    function automatic void build_expected();
        int p = 0;
        bit stop = 0;
        exp_w.delete();
        exp_trunc = 0;
        foreach (qbytes[i]) begin
            if (!stop) begin
                if (qbytes[i] == 0) stop = 1;
                else if (p < (1 << AW) - 1) begin
                    exp_w.push_back({AW'(p), qbytes[i]});
                    p++;
                end else exp_trunc = 1;
            end
        end
        exp_w.push_back({AW'(p), DW'(0)});
    endfunction

    function automatic bit writes_match();
        if (obs_w.size() != exp_w.size()) return 0;
        foreach (exp_w[i]) if (obs_w[i] !== exp_w[i]) return 0;
        return 1;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++)
            if (m[(rr_model + i) % NREQ]) return (rr_model + i) % NREQ;
        return -1;
    endfunction

    function automatic bit exp_done(input int lat);
        return (lat >= 1) && (lat <= TMO);
    endfunction

    function automatic int exp_delay(input int lat);
        return exp_done(lat) ? lat + 1 : TMO + 1;
    endfunction

    task automatic rand_query(input int len, input int zero_pct);
        qbytes.delete();
        for (int i = 0; i < len; i++)
            qbytes.push_back(($urandom_range(0, 99) < zero_pct) ? 8'h00 : 8'($urandom_range(1, 255)));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req = '0; bus.q_valid = 0; bus.q_last = 0; bus.q_data = '0;
        bus.m_done = 0; bus.m_found = 0; bus.m_addr_v = '0; bus.rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rr_model = 0;
    endtask

    // Plays requester, matcher and response sink for one job and records what happens.
    task automatic drive_job(input int lat, input bit fnd, input logic [AW-1:0] va, input int hold);
        int qi = 0;
        int cs_cyc = -1;
        int n = 0;
        bit fin = 0;
        logic prev_mrst = 1'b1;
        logic [AW+2:0] cap = '0;
        obs_w.delete();
        obs_first_rdy = -1; obs_cs_cnt = 0; obs_cs_to_rsp = -1; obs_accepted = 0;
        obs_rsp_cycles = 0; obs_gnt = '0; obs_gnt_ok = 1; obs_mrst_ok = 1;
        obs_stable = 1; obs_bound = 0;
        obs_found = 0; obs_tmo = 0; obs_trunc = 0; obs_addr = '0;
        while (!fin && !obs_bound) begin
            @(posedge clk); #1;
            bus.q_valid   = (qi < qbytes.size());
            bus.q_data    = bus.q_valid ? qbytes[qi] : '0;
            bus.q_last    = bus.q_valid && (qi == qbytes.size() - 1);
            bus.m_done    = (cs_cyc >= 0) && (lat >= 1) && (n >= cs_cyc + lat);
            bus.m_found   = bus.m_done & fnd;
            bus.m_addr_v  = bus.m_done ? va : '0;
            bus.rsp_ready = (obs_rsp_cycles >= hold);
            @(negedge clk);
            if (bus.q_ready && obs_first_rdy < 0) begin
                obs_first_rdy = n;
                obs_gnt = bus.gnt;
            end
            if (obs_first_rdy >= 0 && bus.gnt !== obs_gnt) obs_gnt_ok = 0;
            if (bus.q_valid && bus.q_ready) begin
                qi++;
                obs_accepted++;
            end
            if (bus.iram_we) obs_w.push_back({bus.iram_addr, bus.iram_din});
            if (bus.m_cs) begin
                obs_cs_cnt++;
                cs_cyc = n;
                if (prev_mrst !== 1'b0 || bus.m_rst_n !== 1'b1) obs_mrst_ok = 0;
            end
            prev_mrst = bus.m_rst_n;
            if (bus.rsp_valid) begin
                if (obs_rsp_cycles == 0) begin
                    cap = {bus.rsp_found, bus.rsp_addr, bus.rsp_timeout, bus.rsp_trunc};
                    {obs_found, obs_addr, obs_tmo, obs_trunc} = cap;
                    obs_cs_to_rsp = n - cs_cyc;
                end else if ({bus.rsp_found, bus.rsp_addr, bus.rsp_timeout, bus.rsp_trunc} !== cap) begin
                    obs_stable = 0;
                end
                obs_rsp_cycles++;
                if (bus.rsp_ready) fin = 1;
            end
            n++;
            if (n >= BOUND) obs_bound = 1;
        end
        bus.q_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '1; bus.q_valid = 1; bus.q_last = 1; bus.q_data = 8'h55;
        bus.m_done = 1; bus.m_found = 1; bus.m_addr_v = '1; bus.rsp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", bus.gnt); end
        n_checks++; if (bus.q_ready !== 1'b0) begin n_fail++; $display("FAIL reset_q_ready got %b want 0", bus.q_ready); end
        n_checks++; if (bus.iram_we !== 1'b0) begin n_fail++; $display("FAIL reset_iram_we got %b want 0", bus.iram_we); end
        n_checks++; if (bus.m_rst_n !== 1'b0 || bus.m_cs !== 1'b0) begin n_fail++; $display("FAIL reset_matcher got rst_n=%b cs=%b want 0 0", bus.m_rst_n, bus.m_cs); end
        n_checks++; if ({bus.rsp_valid, bus.rsp_found, bus.rsp_addr, bus.rsp_timeout, bus.rsp_trunc} !== '0) begin
            n_fail++; $display("FAIL reset_rsp got v=%b f=%b a=%h t=%b tr=%b want all 0", bus.rsp_valid, bus.rsp_found, bus.rsp_addr, bus.rsp_timeout, bus.rsp_trunc);
        end
`ifdef MATCH_SCHED_STATS_EN
        n_checks++; if ({stat_jobs, stat_hits, stat_timeouts} !== '0) begin n_fail++; $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", stat_jobs, stat_hits, stat_timeouts); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = '0; bus.q_valid = 0; bus.q_last = 0; bus.q_data = '0;
        bus.m_done = 0; bus.m_found = 0; bus.m_addr_v = '0; bus.rsp_ready = 0;
        rr_model = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.q_ready !== 1'b0 || bus.gnt !== '0) begin n_fail++; $display("FAIL idle_no_req got q_ready=%b gnt=%b want 0 0", bus.q_ready, bus.gnt); end
    endtask

    task automatic test_single();
        qbytes.delete();
        qbytes.push_back(8'h61);
        qbytes.push_back(8'h62);
        build_expected();
        @(posedge clk); #1;
        bus.req = 4'b0001;
        drive_job(3, 1'b1, 4'd5, 2);
        n_checks++; if (obs_bound) begin n_fail++; $display("FAIL single_bound got stuck want rsp within %0d cycles", BOUND); end
        n_checks++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got %b want 0001", obs_gnt); end
        n_checks++; if (obs_first_rdy != 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", obs_first_rdy); end
        n_checks++; if (!writes_match()) begin n_fail++; $display("FAIL single_writes got %0d writes want %0d", obs_w.size(), exp_w.size()); end
        n_checks++; if (!obs_mrst_ok || obs_cs_cnt != 1) begin n_fail++; $display("FAIL single_mstart got ok=%b cs=%0d want 1 1", obs_mrst_ok, obs_cs_cnt); end
        n_checks++; if (obs_cs_to_rsp != exp_delay(3)) begin n_fail++; $display("FAIL single_delay got %0d want %0d", obs_cs_to_rsp, exp_delay(3)); end
        n_checks++; if ({obs_found, obs_addr, obs_tmo, obs_trunc} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_rsp got f=%b a=%0d t=%b tr=%b want 1 5 0 0", obs_found, obs_addr, obs_tmo, obs_trunc);
        end
        n_checks++; if (!obs_gnt_ok || !obs_stable) begin n_fail++; $display("FAIL single_hold got gnt_ok=%b stable=%b want 1 1", obs_gnt_ok, obs_stable); end
        n_checks++; if (obs_accepted != 2) begin n_fail++; $display("FAIL single_accept got %0d want 2", obs_accepted); end
        rr_model = 1;
        @(posedge clk); #1;
        bus.req = '0;
        @(negedge clk);
        n_checks++; if (bus.gnt !== '0 || bus.m_rst_n !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_release got gnt=%b rst_n=%b v=%b want 0 0 0", bus.gnt, bus.m_rst_n, bus.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int g;
        apply_reset();
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            rand_query($urandom_range(1, 5), 0);
            build_expected();
            g = pick(4'b1111);
            drive_job($urandom_range(1, 8), 1'b0, '0, 0);
            n_checks++; if (obs_gnt !== NREQ'(1 << g)) begin n_fail++; $display("FAIL rr_gnt job%0d got %b want %b", j, obs_gnt, NREQ'(1 << g)); end
            n_checks++; if (!writes_match() || obs_bound) begin n_fail++; $display("FAIL rr_writes job%0d got %0d writes want %0d", j, obs_w.size(), exp_w.size()); end
            rr_model = (g + 1) % NREQ;
        end
        bus.req = '0;
    endtask

    task automatic test_timeout();
        int lats[3] = '{-1, TMO, TMO + 1};
        int g;
        foreach (lats[k]) begin
            qbytes.delete();
            qbytes.push_back(8'h71);
            build_expected();
            bus.req = 4'b0001;
            g = pick(4'b0001);
            drive_job(lats[k], 1'b1, 4'd9, 0);
            rr_model = (g + 1) % NREQ;
            n_checks++; if (obs_cs_to_rsp != exp_delay(lats[k])) begin n_fail++; $display("FAIL tmo_delay lat=%0d got %0d want %0d", lats[k], obs_cs_to_rsp, exp_delay(lats[k])); end
            n_checks++; if (obs_tmo !== !exp_done(lats[k])) begin n_fail++; $display("FAIL tmo_flag lat=%0d got %b want %b", lats[k], obs_tmo, !exp_done(lats[k])); end
            n_checks++; if (obs_found !== exp_done(lats[k]) || obs_addr !== (exp_done(lats[k]) ? 4'd9 : 4'd0)) begin
                n_fail++; $display("FAIL tmo_fields lat=%0d got f=%b a=%0d", lats[k], obs_found, obs_addr);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_trunc();
        int lens[4] = '{20, 15, 1, 5};
        int g;
        foreach (lens[k]) begin
            rand_query(lens[k], 0);
            if (k == 2) qbytes[0] = 8'h00;
            if (k == 3) qbytes[2] = 8'h00;
            build_expected();
            bus.req = 4'b0010;
            g = pick(4'b0010);
            drive_job(2, 1'b0, '0, 0);
            rr_model = (g + 1) % NREQ;
            n_checks++; if (!writes_match()) begin n_fail++; $display("FAIL trunc_writes len=%0d got %0d writes want %0d", lens[k], obs_w.size(), exp_w.size()); end
            n_checks++; if (obs_trunc !== exp_trunc) begin n_fail++; $display("FAIL trunc_flag len=%0d got %b want %b", lens[k], obs_trunc, exp_trunc); end
            n_checks++; if (obs_accepted != lens[k]) begin n_fail++; $display("FAIL trunc_accept len=%0d got %0d want %0d", lens[k], obs_accepted, lens[k]); end
        end
        n_checks++; if (exp_w[0] !== {4'd0, 8'h00} && 0) begin n_fail++; end
        bus.req = '0;
    endtask

    task automatic test_reset_midjob();
        int g;
        bit seen_cs = 0;
        bit rsp_seen = 0;
        int after = 0;
        qbytes.delete();
        qbytes.push_back(8'h61);
        build_expected();
        bus.req = 4'b0100;
        g = pick(4'b0100);
        drive_job(2, 1'b0, '0, 0);
        rr_model = (g + 1) % NREQ;
        n_checks++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_pre_gnt got %b want 0100", obs_gnt); end
        bus.req = 4'b1000;
        for (int n = 0; n < 100 && after < 5; n++) begin
            @(posedge clk); #1;
            bus.q_valid = 1; bus.q_data = 8'h41; bus.q_last = 1;
            bus.m_done = 0; bus.rsp_ready = 1;
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen = 1;
            if (seen_cs) after++;
            if (bus.m_cs) seen_cs = 1;
        end
        n_checks++; if (!seen_cs) begin n_fail++; $display("FAIL abort_reach_wait got no m_cs want m_cs"); end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req = '0; bus.q_valid = 0; bus.q_last = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen = 1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        rr_model = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.gnt != '0) rsp_seen = 1;
            @(posedge clk); #1;
        end
        bus.rsp_ready = 0;
        n_checks++; if (rsp_seen) begin n_fail++; $display("FAIL abort_no_rsp got rsp/gnt activity want none"); end
        qbytes.delete();
        qbytes.push_back(8'h7a);
        qbytes.push_back(8'h79);
        build_expected();
        bus.req = 4'b1100;
        g = pick(4'b1100);
        drive_job(1, 1'b1, 4'd3, 0);
        rr_model = (g + 1) % NREQ;
        n_checks++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_regrant got %b want 0100", obs_gnt); end
        n_checks++; if (!writes_match() || obs_found !== 1'b1 || obs_addr !== 4'd3) begin
            n_fail++; $display("FAIL abort_clean_job got writes=%0d f=%b a=%0d want %0d 1 3", obs_w.size(), obs_found, obs_addr, exp_w.size());
        end
        bus.req = '0;
    endtask

    task automatic test_backpressure();
        int g;
`ifdef MATCH_SCHED_STATS_EN
        logic [15:0] jobs0, hits0;
        jobs0 = stat_jobs;
        hits0 = stat_hits;
`endif
        rand_query(4, 0);
        build_expected();
        bus.req = 4'b1001;
        g = pick(4'b1001);
        drive_job(5, 1'b1, 4'd12, 10);
        rr_model = (g + 1) % NREQ;
        n_checks++; if (obs_rsp_cycles != 11) begin n_fail++; $display("FAIL bp_cycles got %0d want 11", obs_rsp_cycles); end
        n_checks++; if (!obs_stable || !obs_gnt_ok) begin n_fail++; $display("FAIL bp_stable got stable=%b gnt_ok=%b want 1 1", obs_stable, obs_gnt_ok); end
        n_checks++; if (obs_found !== 1'b1 || obs_addr !== 4'd12) begin n_fail++; $display("FAIL bp_fields got f=%b a=%0d want 1 12", obs_found, obs_addr); end
        bus.req = '0;
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef MATCH_SCHED_STATS_EN
        n_checks++; if (stat_jobs !== jobs0 + 16'd1 || stat_hits !== hits0 + 16'd1) begin
            n_fail++; $display("FAIL bp_stats got jobs=%0d hits=%0d want %0d %0d", stat_jobs, stat_hits, jobs0 + 1, hits0 + 1);
        end
`endif
    endtask

    task automatic test_random();
        int g, lat, hold;
        bit fnd;
        logic [AW-1:0] va;
        logic [NREQ-1:0] m;
        for (int j = 0; j < 12; j++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rand_query($urandom_range(1, 20), 8);
            build_expected();
            lat  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, TMO + 3);
            fnd  = 1'($urandom_range(0, 1));
            va   = AW'($urandom_range(0, (1 << AW) - 1));
            hold = $urandom_range(0, 3);
            bus.req = m;
            g = pick(m);
            drive_job(lat, fnd, va, hold);
            rr_model = (g + 1) % NREQ;
            n_checks++; if (obs_bound || obs_gnt !== NREQ'(1 << g)) begin n_fail++; $display("FAIL rand_gnt job%0d req=%b got %b want %b", j, m, obs_gnt, NREQ'(1 << g)); end
            n_checks++; if (!writes_match() || obs_trunc !== exp_trunc) begin
                n_fail++; $display("FAIL rand_ram job%0d got writes=%0d tr=%b want %0d %b", j, obs_w.size(), obs_trunc, exp_w.size(), exp_trunc);
            end
            n_checks++; if (obs_tmo !== !exp_done(lat) || obs_found !== (exp_done(lat) && fnd) || obs_addr !== (exp_done(lat) ? va : '0)) begin
                n_fail++; $display("FAIL rand_rsp job%0d lat=%0d got t=%b f=%b a=%0d", j, lat, obs_tmo, obs_found, obs_addr);
            end
            n_checks++; if (obs_cs_to_rsp != exp_delay(lat)) begin n_fail++; $display("FAIL rand_delay job%0d got %0d want %0d", j, obs_cs_to_rsp, exp_delay(lat)); end
        end
        bus.req = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_trunc();
        test_reset_midjob();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
